// File: rtl/chacha_loader_if.sv
// Byte-serial load bus and word-write bus of the ChaCha20 input stage.
// master: the loader's client (drives the load strobes and bytes, observes the word writes).
// slave : chacha_loader itself.
//   wr_key/wr_nnc/wr_ctr : start a key/nonce/counter load, first byte on data_in the same cycle
//   hold                 : stall byte sampling
//   ctr_inc              : increment the block counter
//   data_in              : byte stream, least-significant byte of each word first
//   busy                 : a load is in progress
//   word_valid/addr/data : one-cycle state-word write
//   *_loaded, ctr_wrap   : status flags
//   counter              : current block counter
interface chacha_loader_if;
  logic        wr_key;
  logic        wr_nnc;
  logic        wr_ctr;
  logic        hold;
  logic        ctr_inc;
  logic [7:0]  data_in;
  logic        busy;
  logic        word_valid;
  logic [3:0]  word_addr;
  logic [31:0] word_data;
  logic        key_loaded;
  logic        nnc_loaded;
  logic        ctr_loaded;
  logic        ctr_wrap;
  logic [31:0] counter;

  modport master (
    output wr_key, wr_nnc, wr_ctr, hold, ctr_inc, data_in,
    input  busy, word_valid, word_addr, word_data, key_loaded, nnc_loaded, ctr_loaded,
           ctr_wrap, counter
  );

  modport slave (
    input  wr_key, wr_nnc, wr_ctr, hold, ctr_inc, data_in,
    output busy, word_valid, word_addr, word_data, key_loaded, nnc_loaded, ctr_loaded,
           ctr_wrap, counter
  );
endinterface

// File: rtl/chacha_loader.sv
// ChaCha20 input stage: assembles byte-serial key, nonce and counter streams into
// little-endian 32-bit words and writes them into the RFC 8439 state-word slots
// (key 4..11, counter 12, nonce 13..15). Also owns the block counter.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : chacha_loader_if.slave (load strobes, bytes, word writes, status)
module chacha_loader #(
  parameter int unsigned KEY_BYTES = 32,
  parameter int unsigned NNC_BYTES = 12,
  parameter int unsigned CTR_BYTES = 4
) (
  input logic           clk,
  input logic           rst_n,
  chacha_loader_if.slave bus
);

  localparam logic [4:0] KeyLast = 5'(KEY_BYTES - 1);
  localparam logic [4:0] NncLast = 5'(NNC_BYTES - 1);
  localparam logic [4:0] CtrLast = 5'(CTR_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StLdKey, StLdNnc, StLdCtr} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;      // bytes 0..2 of the word being assembled
  logic        valid_q, valid_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        key_ld_q, key_ld_d;
  logic        nnc_ld_q, nnc_ld_d;
  logic        ctr_ld_q, ctr_ld_d;
  logic        wrap_q, wrap_d;
  logic [31:0] ctr_q, ctr_d;

  logic [4:0]  last_idx;
  logic [3:0]  word_addr_sel;
  logic [31:0] word;
  logic [31:0] ctr_plus;

  assign word     = {bus.data_in, buf_q};
  assign ctr_plus = ctr_q + 32'd1;

  // Field length and slot address of the word currently being assembled.
  always_comb begin
    last_idx      = CtrLast;
    word_addr_sel = 4'd12;
    unique case (state_q)
      StLdKey: begin
        last_idx      = KeyLast;
        word_addr_sel = 4'd4 + {1'b0, idx_q[4:2]};
      end
      StLdNnc: begin
        last_idx      = NncLast;
        word_addr_sel = 4'd13 + {2'b00, idx_q[3:2]};
      end
      StLdCtr, StIdle: begin
        last_idx      = CtrLast;
        word_addr_sel = 4'd12;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    valid_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    key_ld_d = key_ld_q;
    nnc_ld_d = nnc_ld_q;
    ctr_ld_d = ctr_ld_q;
    wrap_d   = wrap_q;
    ctr_d    = ctr_q;

    unique case (state_q)
      StIdle: begin
        if (!bus.hold && (bus.wr_key || bus.wr_nnc || bus.wr_ctr)) begin
          // The start edge already samples byte 0.
          idx_d       = 5'd1;
          buf_d[7:0]  = bus.data_in;
          if (bus.wr_key) begin
            state_d  = StLdKey;
            key_ld_d = 1'b0;
          end else if (bus.wr_nnc) begin
            state_d  = StLdNnc;
            nnc_ld_d = 1'b0;
          end else begin
            state_d  = StLdCtr;
            ctr_ld_d = 1'b0;
            wrap_d   = 1'b0;
          end
        end else if (bus.ctr_inc) begin
          ctr_d   = ctr_plus;
          valid_d = 1'b1;
          addr_d  = 4'd12;
          data_d  = ctr_plus;
          if (ctr_q == 32'hFFFF_FFFF) wrap_d = 1'b1;
        end
      end
      StLdKey, StLdNnc, StLdCtr: begin
        if (!bus.hold) begin
          idx_d = idx_q + 5'd1;
          case (idx_q[1:0])
            2'd0: buf_d[7:0]   = bus.data_in;
            2'd1: buf_d[15:8]  = bus.data_in;
            2'd2: buf_d[23:16] = bus.data_in;
            default: begin
              valid_d = 1'b1;
              addr_d  = word_addr_sel;
              data_d  = word;
            end
          endcase
          if (idx_q == last_idx) begin
            state_d = StIdle;
            idx_d   = 5'd0;
            unique case (state_q)
              StLdKey: key_ld_d = 1'b1;
              StLdNnc: nnc_ld_d = 1'b1;
              default: begin
                ctr_ld_d = 1'b1;
                ctr_d    = word;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      buf_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      key_ld_q <= 1'b0;
      nnc_ld_q <= 1'b0;
      ctr_ld_q <= 1'b0;
      wrap_q   <= 1'b0;
      ctr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      key_ld_q <= key_ld_d;
      nnc_ld_q <= nnc_ld_d;
      ctr_ld_q <= ctr_ld_d;
      wrap_q   <= wrap_d;
      ctr_q    <= ctr_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.word_valid = valid_q;
  assign bus.word_addr  = addr_q;
  assign bus.word_data  = data_q;
  assign bus.key_loaded = key_ld_q;
  assign bus.nnc_loaded = nnc_ld_q;
  assign bus.ctr_loaded = ctr_ld_q;
  assign bus.ctr_wrap   = wrap_q;
  assign bus.counter    = ctr_q;

endmodule

// File: tb/tb_chacha_loader.sv
// Scoreboard bench for chacha_loader: stimulus pushes expected word writes, a negedge
// monitor pops and compares every word_valid.
module tb_chacha_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  chacha_loader_if bus ();

  chacha_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          valid_cyc[$];
  logic [7:0]  bytes_m[32];

  // Reference model state.
  logic [31:0] m_ctr;
  bit          m_wrap, m_key, m_nnc, m_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write (cycle %0d)",
                 bus.word_addr, bus.word_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_addr", {28'd0, bus.word_addr}, {28'd0, e.addr});
        chk("write_data", bus.word_data, e.data);
      end
    end
  end

  function automatic int field_len(input int kind);
    return (kind == 0) ? 32 : (kind == 1) ? 12 : 4;
  endfunction

  function automatic logic [3:0] slot(input int kind, input int w);
    if (kind == 0) return 4'(4 + w);
    if (kind == 1) return 4'(13 + w);
    return 4'd12;
  endfunction

  function automatic logic [31:0] le_word(input int w);
    return {bytes_m[4*w+3], bytes_m[4*w+2], bytes_m[4*w+1], bytes_m[4*w]};
  endfunction

  task automatic set_wr(input int kind, input logic v);
    if (kind == 0) bus.wr_key = v;
    else if (kind == 1) bus.wr_nnc = v;
    else bus.wr_ctr = v;
  endtask

  task automatic clr_inputs();
    bus.wr_key  = 1'b0;
    bus.wr_nnc  = 1'b0;
    bus.wr_ctr  = 1'b0;
    bus.hold    = 1'b0;
    bus.ctr_inc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      clr_inputs();
      bus.data_in = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_status();
    chk("key_loaded", {31'd0, bus.key_loaded}, {31'd0, m_key});
    chk("nnc_loaded", {31'd0, bus.nnc_loaded}, {31'd0, m_nnc});
    chk("ctr_loaded", {31'd0, bus.ctr_loaded}, {31'd0, m_ctrl});
    chk("ctr_wrap", {31'd0, bus.ctr_wrap}, {31'd0, m_wrap});
    chk("counter", bus.counter, m_ctr);
  endtask

  // Full field load from bytes_m. hold_at inserts hold_len hold cycles before byte hold_at.
  // noise raises competing strobes/ctr_inc at the start and mid-load.
  task automatic do_load(input int kind, input int hold_at, input int hold_len,
                         input bit noise, input bit rnd_hold, output int start_cyc);
    int n;
    n = field_len(kind);
    for (int w = 0; w < n / 4; w++) exp_q.push_back('{addr: slot(kind, w), data: le_word(w)});
    if (kind == 0) m_key = 1'b0;
    else if (kind == 1) m_nnc = 1'b0;
    else begin
      m_ctrl = 1'b0;
      m_wrap = 1'b0;
    end

    clr_inputs();
    set_wr(kind, 1'b1);
    if (noise) begin
      bus.wr_nnc  = 1'b1;
      bus.ctr_inc = 1'b1;
    end
    bus.data_in = bytes_m[0];
    @(posedge clk); #1;
    start_cyc = cyc;
    clr_inputs();
    for (int i = 1; i < n; i++) begin
      int hl;
      hl = (i == hold_at) ? hold_len :
           (rnd_hold && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (hl) begin
        bus.hold    = 1'b1;
        bus.data_in = 8'($urandom);
        @(posedge clk); #1;
      end
      bus.hold = 1'b0;
      if (noise && i == 10) begin
        bus.wr_key  = 1'b1;
        bus.wr_nnc  = 1'b1;
        bus.wr_ctr  = 1'b1;
        bus.ctr_inc = 1'b1;
      end
      bus.data_in = bytes_m[i];
      if (i == n - 1) chk("busy_before_last", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      clr_inputs();
    end
    if (kind == 0) m_key = 1'b1;
    else if (kind == 1) m_nnc = 1'b1;
    else begin
      m_ctrl = 1'b1;
      m_ctr  = le_word(0);
    end
    chk("busy_after_last", {31'd0, bus.busy}, 32'd0);
    check_status();
  endtask

  task automatic do_inc();
    clr_inputs();
    bus.ctr_inc = 1'b1;
    if (m_ctr == 32'hFFFF_FFFF) m_wrap = 1'b1;
    m_ctr = m_ctr + 32'd1;
    exp_q.push_back('{addr: 4'd12, data: m_ctr});
    @(posedge clk); #1;
    clr_inputs();
    check_status();
  endtask

  // Key bytes 0x00..0x1F with word write timing checked against the start edge.
  task automatic key_ramp_check();
    int s;
    for (int i = 0; i < 32; i++) bytes_m[i] = 8'(i);
    valid_cyc.delete();
    do_load(0, -1, 0, 1'b0, 1'b0, s);
    idle(1);
    chk("key_write_count", valid_cyc.size(), 32'd8);
    for (int k = 0; k < 8 && k < valid_cyc.size(); k++)
      chk("key_write_cycle", valid_cyc[k] - s, 4 * k + 3);
  endtask

  task automatic reset_model();
    m_ctr  = '0;
    m_wrap = 1'b0;
    m_key  = 1'b0;
    m_nnc  = 1'b0;
    m_ctrl = 1'b0;
  endtask

  task automatic check_all_zero();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_word_addr", {28'd0, bus.word_addr}, 32'd0);
    chk("rst_word_data", bus.word_data, 32'd0);
    check_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    clr_inputs();
    bus.data_in = 8'd0;
    reset_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    rst_n = 1'b1;
    idle(1);

    // Scenario 1: key ramp.
    key_ramp_check();

    // Scenario 2: counter = 1, then nonce on the very next cycle.
    bytes_m[0] = 8'h01; bytes_m[1] = 8'h00; bytes_m[2] = 8'h00; bytes_m[3] = 8'h00;
    do_load(2, -1, 0, 1'b0, 1'b0, s);
    for (int i = 0; i < 12; i++) bytes_m[i] = 8'h00;
    bytes_m[3] = 8'h09;
    bytes_m[7] = 8'h4A;
    do_load(1, -1, 0, 1'b0, 1'b0, s);
    idle(1);

    // Scenario 3: three hold cycles between key bytes 5 and 6.
    for (int i = 0; i < 32; i++) bytes_m[i] = 8'(i);
    do_load(0, 6, 3, 1'b0, 1'b0, s);
    idle(1);

    // Scenario 4: counter wrap.
    bytes_m[0] = 8'hFE; bytes_m[1] = 8'hFF; bytes_m[2] = 8'hFF; bytes_m[3] = 8'hFF;
    do_load(2, -1, 0, 1'b0, 1'b0, s);
    do_inc();
    do_inc();
    chk("wrap_set", {31'd0, bus.ctr_wrap}, 32'd1);
    for (int i = 0; i < 4; i++) bytes_m[i] = 8'($urandom);
    do_load(2, -1, 0, 1'b0, 1'b0, s);
    chk("wrap_cleared", {31'd0, bus.ctr_wrap}, 32'd0);

    // wr_* with hold high in IDLE is ignored.
    clr_inputs();
    bus.hold   = 1'b1;
    bus.wr_ctr = 1'b1;
    @(posedge clk); #1;
    clr_inputs();
    chk("hold_start_busy", {31'd0, bus.busy}, 32'd0);
    check_status();

    // Scenario 5: competing strobes and ctr_inc during a key load.
    for (int i = 0; i < 32; i++) bytes_m[i] = 8'($urandom);
    do_load(0, -1, 0, 1'b1, 1'b0, s);
    idle(2);

    // Scenario 6: reset after 10 key bytes.
    for (int i = 0; i < 32; i++) bytes_m[i] = 8'($urandom);
    exp_q.push_back('{addr: 4'd4, data: le_word(0)});
    exp_q.push_back('{addr: 4'd5, data: le_word(1)});
    clr_inputs();
    bus.wr_key  = 1'b1;
    bus.data_in = bytes_m[0];
    @(posedge clk); #1;
    clr_inputs();
    for (int i = 1; i < 10; i++) begin
      bus.data_in = bytes_m[i];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_model();
    check_all_zero();
    rst_n = 1'b1;
    idle(3);
    key_ramp_check();

    // Randomised loads, holds and increments.
    for (int t = 0; t < 8; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      for (int i = 0; i < 32; i++) bytes_m[i] = 8'($urandom);
      do_load(kind, -1, 0, 1'b0, 1'b1, s);
      repeat ($urandom_range(0, 2)) do_inc();
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chacha_loader.md
Name: chacha_loader

Overview:
- Upstream input stage of the ChaCha20 core.
- Accepts key, nonce and counter as byte-serial streams on an 8-bit bus.
- Assembles each stream into little-endian 32-bit words and issues single-cycle word writes into the state-word slots defined by RFC 8439.
- Owns the 32-bit block counter and increments it on request between blocks.

Parameters:
- KEY_BYTES, 32, key length in bytes; fixed, multiple of 4.
- NNC_BYTES, 12, nonce length in bytes; fixed, multiple of 4.
- CTR_BYTES, 4, counter length in bytes; fixed.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_key  in  1  start key load; first byte on data_in this cycle
- wr_nnc  in  1  start nonce load; first byte on data_in this cycle
- wr_ctr  in  1  start counter load; first byte on data_in this cycle
- hold  in  1  stall byte sampling
- ctr_inc  in  1  pulse: increment block counter
- data_in  in  8  byte stream, least-significant byte of each word first
- busy  out  1  high while a load is in progress
- word_valid  out  1  one-cycle word write strobe
- word_addr  out  4  state word index, 0..15
- word_data  out  32  assembled word
- key_loaded  out  1  key fully written since last key load start
- nnc_loaded  out  1  nonce fully written
- ctr_loaded  out  1  counter fully written
- ctr_wrap  out  1  sticky: counter wrapped 0xFFFFFFFF->0
- counter  out  32  current block counter value

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, state IDLE, byte index 0, counter register 0. Reset mid-load abandons the load; no partial word is written.
- States: IDLE, LD_KEY, LD_NNC, LD_CTR.
- IDLE start:
  - A wr_* at a posedge with hold low starts a load.
  - That same edge samples byte 0 and moves to the load state.
  - Priority when several wr_* are high: key > nnc > ctr. The losers are dropped.
  - wr_* with hold high in IDLE is ignored.
- Load start clears the matching *_loaded flag. A counter load start also clears ctr_wrap.
- busy = (state != IDLE), registered.
- In a load state, each posedge with hold low samples data_in into byte index i. Index i increments. Byte (i mod 4) goes to bits [8*(i mod 4)+7 : 8*(i mod 4)].
- hold high freezes the index; data_in is ignored that cycle.
- wr_* pulses during a load are ignored and do not restart it.
- Word output:
  - On the edge that samples the 4th byte of a word, word_valid/word_addr/word_data are registered.
  - word_valid is therefore high for exactly the following cycle.
- Address map:
  - Key word k (0..7) -> addr 4+k.
  - Counter -> addr 12.
  - Nonce word n (0..2) -> addr 13+n.
  - Addresses 0..3 are never driven.
- Field completion:
  - On the edge sampling the last byte: the *_loaded flag is set, state returns to IDLE, and busy falls.
  - A new wr_* on the very next cycle is accepted.
- A counter load also writes the assembled word into the counter register on its final edge.
- Increment:
  - ctr_inc at a posedge in IDLE (not the edge a load starts) sets counter <= counter+1, modulo 2^32.
  - Next cycle: word_valid=1, word_addr=12, word_data=new counter.
  - On 0xFFFFFFFF -> 0, ctr_wrap sets and stays set.
  - ctr_inc in a load state, or coincident with a load start, is ignored.
- Throughput: one byte per cycle. Key load is 32 cycles, nonce 12, counter 4. Hold cycles add to each.

Test Plan:
1. Reset, then wr_key pulse with bytes 0x00..0x1F on consecutive cycles, hold low -> eight word_valid pulses, cycles 4,8,...,32 after start. Addr 4..11. First data 0x03020100, last 0x1F1E1D1C. key_loaded=1 and busy=0 after byte 31.
2. wr_ctr with bytes 01 00 00 00, then wr_nnc with bytes 0x00,0x00,0x00,0x09,0x00,0x00,0x00,0x4A,0x00,0x00,0x00,0x00 starting the cycle after ctr completes -> addr12=0x00000001. Nonce addrs 13/14/15 = 0x09000000/0x4A000000/0x00000000. ctr_loaded=nnc_loaded=1.
3. Key load with hold high for 3 cycles between bytes 5 and 6 -> word 1 (addr 5) still 0x07060504. Completion is delayed exactly 3 cycles.
4. Load counter 0xFFFFFFFE (bytes FE FF FF FF), then ctr_inc twice -> writes 0xFFFFFFFF then 0x00000000 to addr 12. ctr_wrap=1 after the second increment. A new wr_ctr clears ctr_wrap.
5. wr_key and wr_nnc high together, then wr_ctr mid-key-load -> only the key load runs (addr 4..11). No addr 12..15 writes. ctr_inc during the load produces no write.
6. rst_n low after 10 key bytes -> all outputs 0 next cycle. No further word_valid. A subsequent full key load behaves as in scenario 1.
